cl_digit_serial_mult: RTL and testbench

Iterative, digit-serial multiplier supporting integer and carry-less (GF(2)[x]) products on one datapath. It generalises the combinational array multiplier with a configurable digit width. It processes DIGIT_WIDTH bits of operand B per cycle under a start/done handshake, which trades latency for area. It sits in the comparison suite beside the array multipliers and is driven by the same operand/mode interface plus a handshake.

---
 rtl/cl_digit_serial_mult.sv | 122 ++++++++++++
 tb/tb_cl_digit_serial_mult.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_digit_serial_mult.sv
// Digit-serial integer / carry-less multiplier: consumes DIGIT_WIDTH bits of B per RUN cycle.
// Optional build macro CL_MULT_SKIP_ZERO_EN ends RUN early once the remaining B digits are all zero.
module cl_digit_serial_mult #(
  parameter int DATA_WIDTH  = 32,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    start,
  input  logic                    carry_option,
  input  logic [DATA_WIDTH-1:0]   in_mult_a,
  input  logic [DATA_WIDTH-1:0]   in_mult_b,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] out_mult_result
);

  // state | meaning
  // IDLE  | waiting for start (with enable high)
  // RUN   | one digit of B folded into acc per cycle
  // DONE  | done pulse, result valid; returns to IDLE
  localparam int N  = DATA_WIDTH;
  localparam int D  = DIGIT_WIDTH;
  localparam int K  = N / D;
  localparam int P  = 2 * N;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [P-1:0]  a_sh, acc, acc_nxt, pp_int, pp_clm;
  logic [N-1:0]  b_sh, b_nxt;
  logic [CW-1:0] cnt;
  logic          mode;
  logic          last_digit;

  assign b_nxt = b_sh >> D;

`ifdef CL_MULT_SKIP_ZERO_EN
  assign last_digit = (cnt == CW'(K - 1)) || (b_nxt == '0);
`else
  assign last_digit = (cnt == CW'(K - 1));
`endif

  // Both partial-product flavours come from the same shifted copies of a_sh.
  always_comb begin
    pp_int = '0;
    pp_clm = '0;
    for (int i = 0; i < D; i++) begin
      if (b_sh[i]) begin
        pp_int = pp_int + (a_sh << i);
        pp_clm = pp_clm ^ (a_sh << i);
      end
    end
    acc_nxt = mode ? (acc + pp_int) : (acc ^ pp_clm);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_digit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (!enable) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh            <= '0;
      b_sh            <= '0;
      acc             <= '0;
      cnt             <= '0;
      mode            <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      out_mult_result <= '0;
    end else if (!enable) begin
      a_sh            <= '0;
      b_sh            <= '0;
      acc             <= '0;
      cnt             <= '0;
      mode            <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      out_mult_result <= '0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh <= {{N{1'b0}}, in_mult_a};
            b_sh <= in_mult_b;
            mode <= carry_option;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        S_RUN: begin
          acc  <= acc_nxt;
          a_sh <= a_sh << D;
          b_sh <= b_nxt;
          cnt  <= cnt + CW'(1);
          if (last_digit) begin
            out_mult_result <= acc_nxt;
            done            <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cl_digit_serial_mult.sv
// Self-checking bench for cl_digit_serial_mult: N=8/D=2 vector table and corner sequences,
// plus N=32 random regression across D in {1,4,8,32}; honours CL_MULT_SKIP_ZERO_EN latency.
module tb_cl_digit_serial_mult;

`ifdef CL_MULT_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  always #5 clk = ~clk;

  logic        start8, mode8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;

  cl_digit_serial_mult #(.DATA_WIDTH(8), .DIGIT_WIDTH(2)) u8 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start8), .carry_option(mode8),
    .in_mult_a(a8), .in_mult_b(b8), .busy(busy8), .done(done8), .out_mult_result(res8)
  );

  logic        start32, mode32;
  logic [31:0] a32, b32;
  logic [3:0]  busy32, done32;
  logic [63:0] res32 [4];

  for (genvar g = 0; g < 4; g++) begin : g_d32
    localparam int DW = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 32;
    cl_digit_serial_mult #(.DATA_WIDTH(32), .DIGIT_WIDTH(DW)) u32 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .start(start32), .carry_option(mode32),
      .in_mult_a(a32), .in_mult_b(b32), .busy(busy32[g]), .done(done32[g]),
      .out_mult_result(res32[g])
    );
  end

  int nerr = 0;
  int nchk = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_clmul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r = '0;
    for (int i = 0; i < 32; i++)
      if (b[i]) r = r ^ ({32'b0, a} << i);
    return r;
  endfunction

  // Scoreboards: expected results pushed at stimulus time, consumed on done.
  logic [15:0] q8[$];
  logic [63:0] q32[$];
  int dcnt [4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) check("u8_spurious_done", 64'd1, 64'd0);
      else check("u8_result", {48'b0, res8}, {48'b0, q8.pop_front()});
    end
    for (int k = 0; k < 4; k++) begin
      if (done32[k]) begin
        dcnt[k]++;
        if (q32.size() == 0) check($sformatf("u32_k%0d_spurious_done", k), 64'd1, 64'd0);
        else check($sformatf("u32_k%0d_result", k), res32[k], q32[0]);
      end
    end
  end

  typedef struct {
    logic [7:0]  a, b;
    logic        m;
    logic [15:0] r;
    int          lat_full, lat_skip;
  } vec8_t;
  vec8_t tbl [8];

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic m,
                      input logic [15:0] r, input int exp_lat);
    int lat;
    @(negedge clk);
    a8 = a; b8 = b; mode8 = m; start8 = 1'b1;
    q8.push_back(r);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; a8 = ~a; b8 = ~b;
    check("u8_busy_run", {63'b0, busy8}, 64'd1);
    lat = 0;
    while (!done8 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("u8_latency", 64'(lat), 64'(exp_lat));
    @(negedge clk);
    check("u8_busy_after", {63'b0, busy8}, 64'd0);
    check("u8_done_pulse", {63'b0, done8}, 64'd0);
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic m);
    int base [4];
    int cyc;
    bit all;
    @(negedge clk);
    a32 = a; b32 = b; mode32 = m; start32 = 1'b1;
    q32.push_back(m ? ({32'b0, a} * {32'b0, b}) : ref_clmul(a, b));
    for (int k = 0; k < 4; k++) base[k] = dcnt[k];
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0; a32 = $urandom; b32 = $urandom;
    cyc = 0;
    all = 1'b0;
    while (!all && cyc < 80) begin
      @(negedge clk); #1;
      cyc++;
      all = 1'b1;
      for (int k = 0; k < 4; k++) if (dcnt[k] == base[k]) all = 1'b0;
    end
    check("u32_timeout", {63'b0, all}, 64'd1);
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("u32_k%0d_done_count", k), 64'(dcnt[k] - base[k]), 64'd1);
    if (q32.size() != 0) void'(q32.pop_front());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, s, j, lat1;
    logic [31:0] ra, rb;

    tbl[0] = '{8'hFF, 8'hFF, 1'b1, 16'hFE01, 4, 4};
    tbl[1] = '{8'hFF, 8'hFF, 1'b0, 16'h5555, 4, 4};
    tbl[2] = '{8'h03, 8'h03, 1'b1, 16'h0009, 4, 1};
    tbl[3] = '{8'h03, 8'h03, 1'b0, 16'h0005, 4, 1};
    tbl[4] = '{8'h12, 8'h34, 1'b1, 16'h03A8, 4, 3};
    tbl[5] = '{8'h12, 8'h34, 1'b0, 16'h0328, 4, 3};
    tbl[6] = '{8'h80, 8'h80, 1'b0, 16'h4000, 4, 4};
    tbl[7] = '{8'hA5, 8'h00, 1'b1, 16'h0000, 4, 1};

    start8 = 0; mode8 = 0; a8 = 0; b8 = 0;
    start32 = 0; mode32 = 0; a32 = 0; b32 = 0;
    enable = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    check("rst_busy8", {63'b0, busy8}, 64'd0);
    check("rst_done8", {63'b0, done8}, 64'd0);
    check("rst_res8", {48'b0, res8}, 64'd0);
    check("rst_res32", res32[1], 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;

    for (int i = 0; i < 8; i++)
      run8(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].r, SKIP ? tbl[i].lat_skip : tbl[i].lat_full);

    // start held high, operands disturbed during RUN
    lat1 = SKIP ? 2 : 4;
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h0F; mode8 = 1'b1; start8 = 1'b1;
    q8.push_back(16'h00E1);
    @(posedge clk);
    @(negedge clk);
    check("hold_busy", {63'b0, busy8}, 64'd1);
    t = 0;
    while (!done8 && t < 30) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
      t++;
    end
    check("hold_latency", 64'(t), 64'(lat1));
    q8.push_back(16'h000F);
    a8 = 8'h03; b8 = 8'h05;
    s = t;
    @(negedge clk); s++;
    check("hold_idle_gap", {63'b0, busy8}, 64'd0);
    @(negedge clk); s++;
    check("hold_reaccept", {63'b0, busy8}, 64'd1);
    check("hold_spacing", 64'(s), 64'(lat1 + 2));
    start8 = 1'b0;
    j = 0;
    while (!done8 && j < 50) begin
      @(negedge clk);
      j++;
    end
    check("hold_second_done", {63'b0, done8}, 64'd1);
    @(negedge clk);

    // async reset mid-RUN at cnt=2
    a8 = 8'hFF; b8 = 8'hFF; mode8 = 1'b1; start8 = 1'b1;
    q8.push_back(16'hFE01);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {63'b0, busy8}, 64'd0);
    check("mid_rst_done", {63'b0, done8}, 64'd0);
    check("mid_rst_res", {48'b0, res8}, 64'd0);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run8(tbl[4].a, tbl[4].b, tbl[4].m, tbl[4].r, SKIP ? tbl[4].lat_skip : tbl[4].lat_full);

    // enable dropped for one cycle mid-RUN
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; mode8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("en_drop_busy", {63'b0, busy8}, 64'd0);
    check("en_drop_res", {48'b0, res8}, 64'd0);
    enable = 1'b1;
    repeat (8) @(negedge clk);
    check("en_drop_no_done", {63'b0, busy8}, 64'd0);
    enable = 1'b0;
    start8 = 1'b1;
    repeat (3) @(negedge clk);
    check("en_low_no_accept", {63'b0, busy8}, 64'd0);
    start8 = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    check("en_low_still_idle", {63'b0, busy8}, 64'd0);
    run8(tbl[0].a, tbl[0].b, tbl[0].m, tbl[0].r, 4);

    // N=32 regression across digit widths
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run32(32'h1234_5678, 32'h0000_0000, 1'b1);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'h0000_0001;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       rb = 32'h0000_0000;
        1:       rb = 32'($urandom_range(0, 255));
        default: rb = $urandom;
      endcase
      run32(ra, rb, 1'($urandom_range(0, 1)));
    end

    check("sb8_empty", 64'(q8.size()), 64'd0);
    check("sb32_empty", 64'(q32.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
